// File: rtl/out_display.sv
// Output display block: captures a byte from the shared bus, converts it to
// signed decimal with a sequential double-dabble, and scans four 7-segment digits.
module out_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] bus,
    input  logic       sgn,
    output logic [7:0] value,
    output logic       busy,
    output logic [3:0] dig,
    output logic [6:0] seg,
    output logic       fsm_state
);

    typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    state_t      state;
    logic        neg_work;
    logic [7:0]  mag;
    logic [11:0] bcd;
    logic [2:0]  cnt;

    logic [3:0]  disp_h;
    logic [3:0]  disp_t;
    logic [3:0]  disp_o;
    logic        disp_neg;

    logic [15:0] div_cnt;
    logic [1:0]  idx;
    logic [1:0]  nxt_idx;
    logic [6:0]  seg_next;

    logic [7:0]  load_mag;
    logic [3:0]  o_adj;
    logic [3:0]  t_adj;
    logic [3:0]  h_adj;
    logic [11:0] bcd_step;

    assign fsm_state = (state == CONV);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // 0x80 with sgn=1 negates to 0x80 again, which reads correctly as 128.
    always_comb begin
        load_mag = (sgn && bus[7]) ? 8'(~bus + 8'd1) : bus;
    end

    always_comb begin
        o_adj    = (bcd[3:0]  >= 4'd5) ? bcd[3:0]  + 4'd3 : bcd[3:0];
        t_adj    = (bcd[7:4]  >= 4'd5) ? bcd[7:4]  + 4'd3 : bcd[7:4];
        h_adj    = (bcd[11:8] >= 4'd5) ? bcd[11:8] + 4'd3 : bcd[11:8];
        bcd_step = {h_adj[2:0], t_adj, o_adj, mag[7]};
    end

    // Conversion works in private registers; the display copy only happens on
    // the final step, so an aborted or reset conversion never becomes visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            value    <= 8'h00;
            busy     <= 1'b0;
            neg_work <= 1'b0;
            mag      <= 8'h00;
            bcd      <= 12'h000;
            cnt      <= 3'd0;
            disp_h   <= 4'd0;
            disp_t   <= 4'd0;
            disp_o   <= 4'd0;
            disp_neg <= 1'b0;
        end else if (load) begin
            state    <= CONV;
            value    <= bus;
            busy     <= 1'b1;
            neg_work <= sgn & bus[7];
            mag      <= load_mag;
            bcd      <= 12'h000;
            cnt      <= 3'd0;
        end else if (state == CONV) begin
            bcd <= bcd_step;
            mag <= {mag[6:0], 1'b0};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                disp_h   <= bcd_step[11:8];
                disp_t   <= bcd_step[7:4];
                disp_o   <= bcd_step[3:0];
                disp_neg <= neg_work;
                state    <= IDLE;
                busy     <= 1'b0;
            end
        end
    end

    always_comb begin
        nxt_idx  = (div_cnt == DIV_LAST) ? idx + 2'd1 : idx;
        seg_next = 7'h00;
        case (nxt_idx)
            2'd0: seg_next = seg7(disp_o);
            2'd1: seg_next = (disp_h == 4'd0 && disp_t == 4'd0) ? 7'h00 : seg7(disp_t);
            2'd2: seg_next = (disp_h == 4'd0) ? 7'h00 : seg7(disp_h);
            2'd3: seg_next = disp_neg ? 7'h40 : 7'h00;
            default: seg_next = 7'h00;
        endcase
    end

    // dig and seg are both derived from nxt_idx so they always move together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= 16'd0;
            idx     <= 2'd0;
            dig     <= 4'b0001;
            seg     <= 7'h3F;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? 16'd0 : div_cnt + 16'd1;
            idx     <= nxt_idx;
            dig     <= 4'b0001 << nxt_idx;
            seg     <= seg_next;
        end
    end

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display: reset, unsigned/signed conversion, abort,
// asynchronous reset during conversion, and display hold while busy.
module tb_out_display;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] bus;
    logic       sgn;
    logic [7:0] value;
    logic       busy;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       fsm_state;

    int vectors;
    int miscompares;

    out_display #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .bus(bus), .sgn(sgn),
        .value(value), .busy(busy), .dig(dig), .seg(seg), .fsm_state(fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Collects the segment pattern shown on each digit over one full scan; {sign,h,t,o}.
    task automatic capture(output logic [27:0] disp, output logic [3:0] seen);
        disp = '0;
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (dig)
                4'b0001: begin disp[6:0]   = seg; seen[0] = 1'b1; end
                4'b0010: begin disp[13:7]  = seg; seen[1] = 1'b1; end
                4'b0100: begin disp[20:14] = seg; seen[2] = 1'b1; end
                4'b1000: begin disp[27:21] = seg; seen[3] = 1'b1; end
                default: seen = 4'b0000;
            endcase
        end
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [7:0] b, input logic s);
        @(negedge clk);
        load = 1'b1;
        bus  = b;
        sgn  = s;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        rst = 1'b0; load = 1'b0; bus = 8'h00; sgn = 1'b0;
        #12;
        vectors++;
        if ({value, busy, dig, seg} !== {8'h00, 1'b0, 4'b0001, 7'h3F}) begin
            miscompares++;
            $display("FAIL reset_values: value=%h busy=%b dig=%b seg=%h, need 00 0 0001 3F",
                     value, busy, dig, seg);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            exp_dig = 4'b0001 << ((k / 4) % 4);
            exp_seg = (exp_dig == 4'b0001) ? 7'h3F : 7'h00;
            vectors++;
            if (dig !== exp_dig || seg !== exp_seg || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_scan[%0d]: dig=%b seg=%h busy=%b, need dig=%b seg=%h busy=0",
                         k, dig, seg, busy, exp_dig, exp_seg);
            end
        end
    endtask

    task automatic test_load_255;
        logic [27:0] disp;
        logic [3:0]  seen;
        do_load(8'hFF, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if (busy !== (i < 8)) begin
                miscompares++;
                $display("FAIL busy_255[%0d]: busy=%b, need %b", i, busy, (i < 8));
            end
        end
        vectors++;
        if (value !== 8'hFF) begin
            miscompares++;
            $display("FAIL value_255: value=%h, need ff", value);
        end
        capture(disp, seen);
        vectors++;
        if ({seen, disp} !== {4'hF, 7'h00, 7'h5B, 7'h6D, 7'h6D}) begin
            miscompares++;
            $display("FAIL display_255: seen=%b disp=%h, need seen=1111 disp=%h",
                     seen, disp, {7'h00, 7'h5B, 7'h6D, 7'h6D});
        end
    endtask

    task automatic test_signed;
        logic [27:0] disp;
        logic [3:0]  seen;
        logic        ok;
        logic [7:0]  in_b[3]  = '{8'h80, 8'hF6, 8'h80};
        logic        in_s[3]  = '{1'b1, 1'b1, 1'b0};
        logic [27:0] exp_d[3] = '{{7'h40, 7'h06, 7'h5B, 7'h7F},
                                  {7'h40, 7'h00, 7'h06, 7'h3F},
                                  {7'h00, 7'h06, 7'h5B, 7'h7F}};
        for (int n = 0; n < 3; n++) begin
            do_load(in_b[n], in_s[n]);
            wait_done(ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL signed_done[%0d]: busy=%b after 20 cycles, need 0", n, busy);
            end
            capture(disp, seen);
            vectors++;
            if ({seen, disp} !== {4'hF, exp_d[n]}) begin
                miscompares++;
                $display("FAIL signed_disp[%0d]: seen=%b disp=%h, need seen=1111 disp=%h",
                         n, seen, disp, exp_d[n]);
            end
        end
        // Leave "-10" on the display for the abort test.
        do_load(8'hF6, 1'b1);
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL signed_done_m10: busy=%b, need 0", busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort;
        logic [27:0] disp;
        logic [3:0]  seen;
        logic [6:0]  exp_seg;
        do_load(8'h07, 1'b0);
        @(negedge clk);
        @(negedge clk);
        load = 1'b1;
        bus  = 8'h2A;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if (busy !== (i < 8)) begin
                miscompares++;
                $display("FAIL abort_busy[%0d]: busy=%b, need %b", i, busy, (i < 8));
            end
            if (i < 8) begin
                case (dig)
                    4'b0001: exp_seg = 7'h3F;
                    4'b0010: exp_seg = 7'h06;
                    4'b0100: exp_seg = 7'h00;
                    default: exp_seg = 7'h40;
                endcase
                vectors++;
                if (seg !== exp_seg || !$onehot(dig)) begin
                    miscompares++;
                    $display("FAIL abort_hold[%0d]: dig=%b seg=%h, need seg=%h one-hot dig",
                             i, dig, seg, exp_seg);
                end
            end
        end
        capture(disp, seen);
        vectors++;
        if ({seen, disp} !== {4'hF, 7'h00, 7'h00, 7'h66, 7'h5B}) begin
            miscompares++;
            $display("FAIL abort_disp: seen=%b disp=%h, need seen=1111 disp=%h",
                     seen, disp, {7'h00, 7'h00, 7'h66, 7'h5B});
        end
    endtask

    task automatic test_reset_during_conv;
        logic [27:0] disp;
        logic [3:0]  seen;
        do_load(8'h63, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({value, busy, dig, seg, fsm_state} !== {8'h00, 1'b0, 4'b0001, 7'h3F, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: value=%h busy=%b dig=%b seg=%h st=%b, need 00 0 0001 3F 0",
                     value, busy, dig, seg, fsm_state);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_busy: busy=%b, need 0", busy);
        end
        capture(disp, seen);
        vectors++;
        if ({seen, disp} !== {4'hF, 7'h00, 7'h00, 7'h00, 7'h3F}) begin
            miscompares++;
            $display("FAIL post_reset_disp: seen=%b disp=%h, need seen=1111 disp=%h",
                     seen, disp, {7'h00, 7'h00, 7'h00, 7'h3F});
        end
    endtask

    task automatic test_load_after_reset;
        logic [27:0] disp;
        logic [3:0]  seen;
        logic        ok;
        @(negedge clk);
        rst  = 1'b0;
        load = 1'b1;
        bus  = 8'h0C;
        sgn  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load = 1'b0;
        vectors++;
        if (value !== 8'h0C || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_edge_load: value=%h busy=%b, need 0c 1", value, busy);
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL first_edge_done: busy=%b, need 0", busy);
        end
        capture(disp, seen);
        vectors++;
        if ({seen, disp} !== {4'hF, 7'h00, 7'h00, 7'h06, 7'h5B}) begin
            miscompares++;
            $display("FAIL first_edge_disp: seen=%b disp=%h, need seen=1111 disp=%h",
                     seen, disp, {7'h00, 7'h00, 7'h06, 7'h5B});
        end
    endtask

    task automatic test_display_hold;
        logic [27:0] disp;
        logic [3:0]  seen;
        logic        ok;
        logic [6:0]  exp_seg;
        do_load(8'hFF, 1'b0);
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL hold_setup_done: busy=%b, need 0", busy);
        end
        repeat (2) @(negedge clk);
        do_load(8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            case (dig)
                4'b0001: exp_seg = 7'h6D;
                4'b0010: exp_seg = 7'h6D;
                4'b0100: exp_seg = 7'h5B;
                default: exp_seg = 7'h00;
            endcase
            vectors++;
            if (busy !== 1'b1 || seg !== exp_seg || !$onehot(dig)) begin
                miscompares++;
                $display("FAIL hold_255[%0d]: busy=%b dig=%b seg=%h, need busy=1 seg=%h one-hot dig",
                         i, busy, dig, seg, exp_seg);
            end
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL hold_done: busy=%b, need 0", busy);
        end
        capture(disp, seen);
        vectors++;
        if ({seen, disp} !== {4'hF, 7'h00, 7'h00, 7'h00, 7'h3F}) begin
            miscompares++;
            $display("FAIL hold_zero_disp: seen=%b disp=%h, need seen=1111 disp=%h",
                     seen, disp, {7'h00, 7'h00, 7'h00, 7'h3F});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_load_255();
        test_signed();
        test_abort();
        test_reset_during_conv();
        test_load_after_reset();
        test_display_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
